// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the 16-bit multicycle CPU control path.
// Includes opcodes, ALU control codes, the FSM state encoding and the per-state control decode.
package multicycle_control_pkg;

  localparam logic [3:0] OP_R0   = 4'b0000;
  localparam logic [3:0] OP_R1   = 4'b0001;
  localparam logic [3:0] OP_R2   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUBI = 4'b1010;
  localparam logic [3:0] OP_SLTI = 4'b1011;
  localparam logic [3:0] OP_LW   = 4'b1100;
  localparam logic [3:0] OP_SW   = 4'b1101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // Encoding is visible on the debug port, so the values are fixed explicitly.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_R     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ILLEGAL
  } op_class_t;

  // Moore part of the control word; fetch/branch qualify the MemReady/Zero dependent strobes.
  typedef struct packed {
    logic       fetch;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       i_or_d;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic op_class_t classify(input logic [3:0] opcode);
    case (opcode)
      OP_R0, OP_R1, OP_R2:       classify = CLS_R;
      OP_ADDI, OP_SUBI, OP_SLTI: classify = CLS_I;
      OP_LW:                     classify = CLS_LW;
      OP_SW:                     classify = CLS_SW;
      OP_BEQ:                    classify = CLS_BEQ;
      default:                   classify = CLS_ILLEGAL;
    endcase
  endfunction

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_ONE;
        c.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BOFF;
        c.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_R;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_I;
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_WB_I:   c.reg_write = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        c.branch    = 1'b1;
        c.pc_src    = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath boundary for the multicycle CPU controller.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;

  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_src;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             illegal_op;
  logic [CNT_W-1:0] retired_cnt;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           illegal_op, retired_cnt, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           illegal_op, retired_cnt, state_dbg
  );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle CPU: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing,
// memory ready handshake, retired-instruction counter and sticky halt on illegal opcodes.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  state_t           state;
  state_t           state_n;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_o;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  op_class_t        op_cls;
  logic             retire;

  assign op_cls = classify(bus.opcode);

  // NOTE: every variable gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:    state_n = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_cls)
          CLS_R:         state_n = S_EXEC_R;
          CLS_I:         state_n = S_EXEC_I;
          CLS_LW, CLS_SW: state_n = S_MEM_ADDR;
          CLS_BEQ:       state_n = S_BRANCH;
          default:       state_n = S_HALT;
        endcase
      end
      S_EXEC_R:   state_n = S_WB_R;
      S_EXEC_I:   state_n = S_WB_I;
      S_MEM_ADDR: state_n = (op_cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_n = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_n = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_HALT:     state_n = S_HALT;
      default:    state_n = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state)
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH: retire = 1'b1;
      S_MEM_WR:                           retire = bus.mem_ready;
      default:                            retire = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  // The control word is decoded from the next state, giving glitch-free Moore outputs one
  // register stage away from the state flops but aligned with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      ctrl_q    <= decode_state(S_FETCH);
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state  <= state_n;
      ctrl_q <= decode_state(state_n);
      if (state_n == S_HALT) illegal_q <= 1'b1;
      if (retire)            cnt_q     <= cnt_q + 1'b1;
    end
  end

  // Reset holds every strobe and select low even while the state register still shows the
  // interrupted instruction.
  always_comb ctrl_o = rst ? '0 : ctrl_q;

  assign bus.pc_write      = ctrl_o.fetch & bus.mem_ready;
  assign bus.ir_write      = ctrl_o.fetch & bus.mem_ready;
  assign bus.pc_write_cond = ctrl_o.branch & bus.zero;
  assign bus.pc_src        = ctrl_o.pc_src;
  assign bus.i_or_d        = ctrl_o.i_or_d;
  assign bus.mem_read      = ctrl_o.mem_read;
  assign bus.mem_write     = ctrl_o.mem_write;
  assign bus.reg_write     = ctrl_o.reg_write;
  assign bus.reg_dst       = ctrl_o.reg_dst;
  assign bus.mem_to_reg    = ctrl_o.mem_to_reg;
  assign bus.alu_src_a     = ctrl_o.alu_src_a;
  assign bus.alu_src_b     = ctrl_o.alu_src_b;
  assign bus.alu_op        = ctrl_o.alu_op;
  assign bus.illegal_op    = illegal_q;
  assign bus.retired_cnt   = cnt_q;
  assign bus.state_dbg     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a random instruction mix,
// compared cycle by cycle against an instruction-level model of the control sequence.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(16)) bus ();
  multicycle_control_if #(.CNT_W(3))  wbus ();

  multicycle_control #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter twin sees the same inputs; it exercises counter wrap in a few instructions.
  multicycle_control #(.CNT_W(3)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  assign wbus.opcode    = bus.opcode;
  assign wbus.zero      = bus.zero;
  assign wbus.mem_ready = bus.mem_ready;

  typedef struct {
    state_t     st;
    bit         ready;
    bit         zero;
    logic [3:0] op;
  } cyc_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned model_cnt = 0;
  bit          model_illegal = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // strb = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write}
  // sel  = {pc_src, i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op}; msk marks fields
  // that the state actually defines.
  function automatic void expect_for(input state_t s, input bit r, input bit z,
                                     output logic [5:0] strb, output logic [8:0] sel,
                                     output logic [8:0] msk);
    strb = 6'b0;
    sel  = 9'b0;
    msk  = 9'b0;
    case (s)
      S_FETCH:    begin strb = {r, 1'b0, 1'b1, 1'b0, r, 1'b0};
                        sel = 9'b0_0_00_0_01_00; msk = 9'b0_1_00_1_11_11; end
      S_DECODE:   begin sel = 9'b0_0_00_0_11_00; msk = 9'b0_0_00_1_11_11; end
      S_EXEC_R:   begin sel = 9'b0_0_00_1_00_10; msk = 9'b0_0_00_1_11_11; end
      S_EXEC_I:   begin sel = 9'b0_0_00_1_10_11; msk = 9'b0_0_00_1_11_11; end
      S_WB_R:     begin strb = 6'b000001; sel = 9'b0_0_10_0_00_00; msk = 9'b0_0_11_0_00_00; end
      S_WB_I:     begin strb = 6'b000001; sel = 9'b0_0_00_0_00_00; msk = 9'b0_0_11_0_00_00; end
      S_MEM_ADDR: begin sel = 9'b0_0_00_1_10_00; msk = 9'b0_0_00_1_11_11; end
      S_MEM_RD:   begin strb = 6'b001000; sel = 9'b0_1_00_0_00_00; msk = 9'b0_1_00_0_00_00; end
      S_WB_MEM:   begin strb = 6'b000001; sel = 9'b0_0_01_0_00_00; msk = 9'b0_0_11_0_00_00; end
      S_MEM_WR:   begin strb = 6'b000100; sel = 9'b0_1_00_0_00_00; msk = 9'b0_1_00_0_00_00; end
      S_BRANCH:   begin strb = {1'b0, z, 4'b0000};
                        sel = 9'b1_0_00_1_00_01; msk = 9'b1_0_00_1_11_11; end
      default:    begin strb = 6'b0; msk = 9'b0; end
    endcase
  endfunction

  function automatic logic [5:0] obs_strb();
    return {bus.pc_write, bus.pc_write_cond, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_write};
  endfunction

  function automatic logic [8:0] obs_sel();
    return {bus.pc_src, bus.i_or_d, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op};
  endfunction

  function automatic cyc_t mk(input state_t s, input bit r, input logic [3:0] op, input bit z);
    cyc_t c;
    c.st = s; c.ready = r; c.op = op; c.zero = z;
    return c;
  endfunction

  // Drive one cycle's inputs, check outputs at the falling edge, advance past the rising edge.
  task automatic step(input cyc_t c);
    logic [5:0] es;
    logic [8:0] ev, em;
    bus.mem_ready = c.ready;
    bus.zero      = c.zero;
    bus.opcode    = c.op;
    if (c.st == S_HALT) model_illegal = 1'b1;
    expect_for(c.st, c.ready, c.zero, es, ev, em);
    @(negedge clk);
    chk("state", bus.state_dbg, c.st);
    chk("strobes", obs_strb(), es);
    chk("selects", obs_sel() & em, ev & em);
    chk("illegal_op", bus.illegal_op, model_illegal);
    chk("retired_cnt", bus.retired_cnt, model_cnt[15:0]);
    chk("retired_cnt_w3", wbus.retired_cnt, model_cnt[2:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b1;
    bus.opcode = OP_SW;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_strobes", obs_strb(), 6'b0);
      chk("reset_selects", obs_sel(), 9'b0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_cnt = 0;
    model_illegal = 1'b0;
    chk("reset_state", bus.state_dbg, S_FETCH);
    chk("reset_cnt", bus.retired_cnt, 16'h0);
    chk("reset_illegal", bus.illegal_op, 1'b0);
  endtask

  // Expected cycle sequence of one instruction; abort_at >= 0 stops after that many cycles.
  task automatic run_instr(input logic [3:0] op, input bit z, input int fwait, input int mwait,
                           input int abort_at);
    cyc_t q[$];
    int   n;
    for (int i = 0; i < fwait; i++) q.push_back(mk(S_FETCH, 1'b0, 4'($urandom), 1'($urandom)));
    q.push_back(mk(S_FETCH, 1'b1, 4'($urandom), 1'($urandom)));
    q.push_back(mk(S_DECODE, 1'($urandom), op, 1'($urandom)));
    case (op)
      4'b0000, 4'b0001, 4'b0010: begin
        q.push_back(mk(S_EXEC_R, 1'($urandom), op, 1'($urandom)));
        q.push_back(mk(S_WB_R, 1'($urandom), op, 1'($urandom)));
      end
      4'b1001, 4'b1010, 4'b1011: begin
        q.push_back(mk(S_EXEC_I, 1'($urandom), op, 1'($urandom)));
        q.push_back(mk(S_WB_I, 1'($urandom), op, 1'($urandom)));
      end
      4'b1100, 4'b1101: begin
        q.push_back(mk(S_MEM_ADDR, 1'($urandom), op, 1'($urandom)));
        for (int i = 0; i < mwait; i++)
          q.push_back(mk((op == 4'b1100) ? S_MEM_RD : S_MEM_WR, 1'b0, op, 1'($urandom)));
        q.push_back(mk((op == 4'b1100) ? S_MEM_RD : S_MEM_WR, 1'b1, op, 1'($urandom)));
        if (op == 4'b1100) q.push_back(mk(S_WB_MEM, 1'($urandom), op, 1'($urandom)));
      end
      4'b0100: q.push_back(mk(S_BRANCH, 1'($urandom), op, z));
      default: for (int i = 0; i < 11; i++) q.push_back(mk(S_HALT, 1'($urandom), op, 1'($urandom)));
    endcase
    n = (abort_at >= 0) ? abort_at : q.size();
    for (int i = 0; i < n; i++) step(q[i]);
    if (abort_at < 0 && !model_illegal) begin
      model_cnt++;
      chk("retired_after", bus.retired_cnt, model_cnt[15:0]);
    end
  endtask

  function automatic logic [3:0] pick_legal();
    logic [3:0] legal [9];
    legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
    return legal[$urandom_range(8, 0)];
  endfunction

  function automatic logic [3:0] pick_illegal();
    logic [3:0] bad [7];
    bad = '{4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1110, 4'b1111};
    return bad[$urandom_range(6, 0)];
  endfunction

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    bus.opcode = 4'b0;

    // R-type with zero-wait memory, then LW with a three-cycle memory stall.
    do_reset(2);
    run_instr(4'b0001, 1'b0, 0, 0, -1);
    run_instr(4'b1100, 1'b0, 0, 3, -1);

    // BEQ taken and not taken, a fetch stall, and an I-type.
    run_instr(4'b0100, 1'b1, 0, 0, -1);
    run_instr(4'b0100, 1'b0, 2, 0, -1);
    run_instr(4'b1010, 1'b0, 0, 0, -1);

    // Illegal opcode halts with no strobes until reset.
    run_instr(4'b0111, 1'b0, 0, 0, -1);
    do_reset(1);

    // Eight retirements ending in a SW wrap the 3-bit twin counter back to zero.
    for (int i = 0; i < 7; i++) run_instr(pick_legal(), 1'($urandom), 0, 0, -1);
    run_instr(4'b1101, 1'b0, 0, 1, -1);
    chk("wrap_to_zero", wbus.retired_cnt, 3'd0);
    run_instr(4'b1001, 1'b0, 0, 0, -1);

    // Reset while a SW waits on memory aborts it without a count.
    do_reset(1);
    run_instr(4'b1101, 1'b0, 0, 3, 5);
    do_reset(1);
    chk("abort_no_count", bus.retired_cnt, 16'h0);
    run_instr(4'b0000, 1'b0, 0, 0, -1);

    // Random mix with random stalls; illegal opcodes are followed by a reset.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9, 0) == 0) begin
        run_instr(pick_illegal(), 1'b0, $urandom_range(1, 0), 0, -1);
        do_reset(1);
      end else begin
        run_instr(pick_legal(), 1'($urandom), $urandom_range(2, 0), $urandom_range(2, 0), -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
